// File: rtl/hamming_tx_sched_if.sv
// rtl/hamming_tx_sched_if.sv - source-side request/nibble bus and serial link outputs of hamming_tx_sched
interface hamming_tx_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
);
  logic [NUM_REQ-1:0]   req;
  logic [4*NUM_REQ-1:0] din;
  logic [NUM_REQ-1:0]   ack;
  logic                 out;
  logic                 frame_start;
  logic                 busy;
  logic [IDW-1:0]       gnt_id;

  modport master (output req, din, input ack, out, frame_start, busy, gnt_id);
  modport slave  (input req, din, output ack, out, frame_start, busy, gnt_id);
endinterface

// File: rtl/hamming_tx_sched.sv
// rtl/hamming_tx_sched.sv - round-robin Hamming(7,4) serial frame scheduler
// Optional macro HAMMING_ERR_INJECT_EN adds err_inj/err_pos single-bit fault injection.
module hamming_tx_sched #(
  parameter int NUM_REQ    = 4,
  parameter int IDW        = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  hamming_tx_sched_if.slave bus
`ifdef HAMMING_ERR_INJECT_EN
  ,
  input  logic              err_inj,
  input  logic [2:0]        err_pos
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BIT  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam bit         HAS_GAP = (GAP_CYCLES > 0);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES);

  logic [1:0]         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [3:0]         gap_q, gap_d;
  logic [6:0]         sh_q, sh_d;
  logic [IDW-1:0]     rr_q, rr_d;
  logic [IDW-1:0]     gnt_q, gnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               out_q, out_d;
  logic               fs_q, fs_d;
  logic               busy_q, busy_d;

  logic               found;
  int                 win_idx;
  int                 idx;
  logic [3:0]         nib;
  logic [6:0]         flip;
  logic [6:0]         frame;

  // Scan from rr_q+1 upward with wrap so the last winner has lowest priority.
  always_comb begin
    found   = 1'b0;
    win_idx = 0;
    idx     = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(rr_q) + i) % NUM_REQ;
      if (!found && bus.req[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
  end

  always_comb begin
    nib  = bus.din[4*win_idx +: 4];
    flip = 7'd0;
`ifdef HAMMING_ERR_INJECT_EN
    if (err_inj && err_pos != 3'd0)
      flip = 7'd1 << (err_pos - 3'd1);
`endif
    // Bit 0 leaves the line first: d0..d3 then p0..p2.
    frame = {nib[0] ^ nib[2] ^ nib[3],
             nib[0] ^ nib[1] ^ nib[3],
             nib[0] ^ nib[1] ^ nib[2],
             nib[3], nib[2], nib[1], nib[0]} ^ flip;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    sh_d    = sh_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    out_d   = out_q;
    fs_d    = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        out_d  = 1'b0;
        busy_d = 1'b0;
        if (found) begin
          sh_d           = frame;
          gnt_d          = IDW'(win_idx);
          rr_d           = IDW'(win_idx);
          ack_d[win_idx] = 1'b1;
          fs_d           = 1'b1;
          out_d          = 1'b1;
          busy_d         = 1'b1;
          cnt_d          = 4'd1;
          state_d        = S_BIT;
        end
      end
      S_BIT: begin
        if (cnt_q == 4'd8) begin
          // Without a gap the last parity bit is simply held through the idle cycle.
          if (HAS_GAP) begin
            state_d = S_GAP;
            out_d   = 1'b0;
            gap_d   = 4'd1;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          out_d = sh_q[0];
          sh_d  = sh_q >> 1;
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_GAP: begin
        out_d = 1'b0;
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        out_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      gap_q   <= 4'd0;
      sh_q    <= 7'd0;
      rr_q    <= IDW'(NUM_REQ - 1);
      gnt_q   <= '0;
      ack_q   <= '0;
      out_q   <= 1'b0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      sh_q    <= sh_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      out_q   <= out_d;
      fs_q    <= fs_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.ack         = ack_q;
  assign bus.out         = out_q;
  assign bus.frame_start = fs_q;
  assign bus.busy        = busy_q;
  assign bus.gnt_id      = gnt_q;

endmodule

// File: tb/tb_hamming_tx_sched.sv
// tb/tb_hamming_tx_sched.sv - scoreboard bench for hamming_tx_sched (GAP_CYCLES=2 and GAP_CYCLES=0 instances)
module tb_hamming_tx_sched;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] bits;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  hamming_tx_sched_if #(.NUM_REQ(4), .IDW(2)) a_if ();
  hamming_tx_sched_if #(.NUM_REQ(4), .IDW(2)) b_if ();

`ifdef HAMMING_ERR_INJECT_EN
  logic       err_inj = 1'b0;
  logic [2:0] err_pos = 3'd0;
`endif

  hamming_tx_sched #(.NUM_REQ(4), .IDW(2), .GAP_CYCLES(2)) dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (a_if)
`ifdef HAMMING_ERR_INJECT_EN
    ,
    .err_inj (err_inj),
    .err_pos (err_pos)
`endif
  );

  hamming_tx_sched #(.NUM_REQ(4), .IDW(2), .GAP_CYCLES(0)) dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (b_if)
`ifdef HAMMING_ERR_INJECT_EN
    ,
    .err_inj (1'b0),
    .err_pos (3'd0)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) cyc++;

  // Monitor A: start bit, 7 frame bits, 2 gap cycles, 1 idle cycle.
  int         pos_a = -1;
  logic [10:0] oa, ba;
  logic [3:0] acka0, acka1;
  logic [1:0] ida;
  exp_t       ea;
  always @(negedge clk) begin
    if (!rst_n) begin
      pos_a = -1;
    end else begin
      if (pos_a < 0 && a_if.frame_start) begin
        pos_a = 0;
        ida   = a_if.gnt_id;
        acka0 = a_if.ack;
      end
      if (pos_a >= 0) begin
        oa[10-pos_a] = a_if.out;
        ba[10-pos_a] = a_if.busy;
        if (pos_a == 1) acka1 = a_if.ack;
        if (pos_a == 10) begin
          if (q_a.size() == 0) begin
            chk("a_unexpected_frame", 1, 0);
          end else begin
            ea = q_a.pop_front();
            chk("a_gnt_id", 32'(ida), 32'(ea.id));
            chk("a_ack", 32'(acka0), 32'(4'b0001 << ea.id));
            chk("a_ack_clear", 32'(acka1), 0);
            chk("a_out_seq", 32'(oa), 32'({ea.bits, 3'b000}));
            chk("a_busy_seq", 32'(ba), 32'(11'b11111111110));
          end
          pos_a = -1;
        end else begin
          pos_a++;
        end
      end
    end
  end

  // Monitor B (no gap): 8 frame bits plus the held-parity idle cycle.
  int         pos_b = -1;
  int         last_fs_b = -1;
  logic [8:0] ob, bb;
  logic [3:0] ackb0;
  logic [1:0] idb;
  exp_t       eb;
  always @(negedge clk) begin
    if (!rst_n) begin
      pos_b = -1;
    end else begin
      if (pos_b < 0 && b_if.frame_start) begin
        pos_b = 0;
        idb   = b_if.gnt_id;
        ackb0 = b_if.ack;
        if (last_fs_b >= 0) chk("b_period", 32'(cyc - last_fs_b), 9);
        last_fs_b = cyc;
      end
      if (pos_b >= 0) begin
        ob[8-pos_b] = b_if.out;
        bb[8-pos_b] = b_if.busy;
        if (pos_b == 8) begin
          if (q_b.size() == 0) begin
            chk("b_unexpected_frame", 1, 0);
          end else begin
            eb = q_b.pop_front();
            chk("b_gnt_id", 32'(idb), 32'(eb.id));
            chk("b_ack", 32'(ackb0), 32'(4'b0001 << eb.id));
            chk("b_out_seq", 32'(ob), 32'({eb.bits, eb.bits[0]}));
            chk("b_busy_seq", 32'(bb), 32'(9'b111111110));
          end
          pos_b = -1;
        end else begin
          pos_b++;
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic serve_a(input int n);
    int t;
    for (int k = 0; k < n; k++) begin
      t = 0;
      while (a_if.ack == 4'd0 && t < 60) begin
        @(negedge clk);
        t++;
      end
      chk("a_ack_timeout", 32'(t >= 60), 0);
      a_if.req = a_if.req & ~a_if.ack;
      @(negedge clk);
    end
  endtask

  task automatic serve_b(input int n);
    int t;
    for (int k = 0; k < n; k++) begin
      t = 0;
      while (b_if.ack == 4'd0 && t < 60) begin
        @(negedge clk);
        t++;
      end
      chk("b_ack_timeout", 32'(t >= 60), 0);
      if (k == n - 1) b_if.req = b_if.req & ~b_if.ack;
      @(negedge clk);
    end
  endtask

  task automatic idle_a();
    int t;
    t = 0;
    while ((q_a.size() != 0 || pos_a >= 0 || a_if.busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("a_idle_timeout", 32'(t >= 200), 0);
  endtask

  task automatic idle_b();
    int t;
    t = 0;
    while ((q_b.size() != 0 || pos_b >= 0 || b_if.busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("b_idle_timeout", 32'(t >= 200), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    a_if.req = '0;
    a_if.din = '0;
    b_if.req = '0;
    b_if.din = '0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out", 32'(a_if.out), 0);
    chk("rst_ack", 32'(a_if.ack), 0);
    chk("rst_frame_start", 32'(a_if.frame_start), 0);
    chk("rst_busy", 32'(a_if.busy), 0);
    chk("rst_gnt_id", 32'(a_if.gnt_id), 0);
    chk("rst_b_busy", 32'(b_if.busy), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single source, nibble 1011
    a_if.din[3:0] = 4'b1011;
    q_a.push_back('{2'd0, 8'b11101010});
    a_if.req[0] = 1'b1;
    serve_a(1);
    idle_a();

    // Source 1: all-zero then all-one nibble
    a_if.din[7:4] = 4'b0000;
    q_a.push_back('{2'd1, 8'b10000000});
    a_if.req[1] = 1'b1;
    serve_a(1);
    idle_a();
    a_if.din[7:4] = 4'b1111;
    q_a.push_back('{2'd1, 8'b11111111});
    a_if.req[1] = 1'b1;
    serve_a(1);
    idle_a();

    // All four held from reset, then 0 and 2 re-raised
    a_if.din = 16'b1000_1100_0011_0101;
    q_a.push_back('{2'd0, 8'b11010010});
    q_a.push_back('{2'd1, 8'b11100001});
    q_a.push_back('{2'd2, 8'b10011110});
    q_a.push_back('{2'd3, 8'b10001011});
    a_if.req = 4'b1111;
    do_reset();
    serve_a(4);
    idle_a();
    q_a.push_back('{2'd0, 8'b11010010});
    q_a.push_back('{2'd2, 8'b10011110});
    a_if.req = 4'b0101;
    serve_a(2);
    idle_a();

    // Reset at frame bit 4; pending requests restart from req[0]
    a_if.req = 4'b0011;
    t = 0;
    while (!a_if.frame_start && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("a_fs_timeout", 32'(t >= 60), 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out", 32'(a_if.out), 0);
    chk("midrst_busy", 32'(a_if.busy), 0);
    chk("midrst_ack", 32'(a_if.ack), 0);
    q_a.push_back('{2'd0, 8'b11010010});
    q_a.push_back('{2'd1, 8'b11100001});
    rst_n = 1'b1;
    serve_a(2);
    idle_a();

    // No-gap instance: req[2] held, 0110 repeats every 9 cycles
    b_if.din[11:8] = 4'b0110;
    q_b.push_back('{2'd2, 8'b10110011});
    q_b.push_back('{2'd2, 8'b10110011});
    q_b.push_back('{2'd2, 8'b10110011});
    b_if.req[2] = 1'b1;
    serve_b(3);
    idle_b();

`ifdef HAMMING_ERR_INJECT_EN
    a_if.din[3:0] = 4'b1011;
    err_inj = 1'b1;
    err_pos = 3'd3;
    q_a.push_back('{2'd0, 8'b11111010});
    a_if.req[0] = 1'b1;
    serve_a(1);
    idle_a();
    err_pos = 3'd0;
    q_a.push_back('{2'd0, 8'b11101010});
    a_if.req[0] = 1'b1;
    serve_a(1);
    idle_a();
    err_inj = 1'b0;
`endif

    repeat (5) @(negedge clk);
    chk("a_queue_empty", 32'(q_a.size()), 0);
    chk("b_queue_empty", 32'(q_b.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
